// File: rtl/cv32e40p_ascon_ks_scheduler.sv
// Purpose: schedules one ASCON keystream word per prefetch FIFO slot and decrypts the FIFO head.
// Latency: a push gives perm_req_o on the next cycle; a done gives plaintext for the head in that same cycle (bypass).
// Backpressure: the request is held stable until perm_gnt_i; plain_valid_o low stalls the IF stage.
module cv32e40p_ascon_ks_scheduler #(
    parameter int FIFO_DEPTH      = 2,
    parameter int FIFO_ADDR_DEPTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_push_i,
    input  logic [FIFO_ADDR_DEPTH-1:0] fifo_write_pointer_i,
    input  logic [31:0]                push_addr_i,
    input  logic                       fifo_pop_i,
    input  logic [FIFO_ADDR_DEPTH-1:0] fifo_read_pointer_i,
    input  logic                       fifo_valid_i,
    input  logic                       flush_i,
    input  logic [31:0]                cipher_rdata_i,
    output logic [31:0]                plain_rdata_o,
    output logic                       plain_valid_o,
    output logic                       perm_req_o,
    output logic [31:0]                perm_nonce_o,
    input  logic                       perm_gnt_i,
    input  logic                       perm_done_i,
    input  logic [31:0]                perm_keystream_i,
    output logic                       busy_o,
    output logic                       protocol_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    localparam logic [FIFO_ADDR_DEPTH-1:0] LAST_IDX = FIFO_ADDR_DEPTH'(FIFO_DEPTH - 1);

    state_t                     state;
    logic [FIFO_ADDR_DEPTH-1:0] cur;
    logic [FIFO_DEPTH-1:0]      pending;
    logic [FIFO_DEPTH-1:0]      ready;
    logic [31:0]                addr [FIFO_DEPTH];
    logic [31:0]                ks   [FIFO_DEPTH];

    logic [FIFO_DEPTH-1:0]      push_hit;
    logic [FIFO_DEPTH-1:0]      pend_eff;
    logic                       rp_ok;
    logic                       wp_ok;
    logic [FIFO_ADDR_DEPTH-1:0] rp_safe;
    logic                       sel_vld;
    logic [FIFO_ADDR_DEPTH-1:0] sel_idx;
    logic [FIFO_ADDR_DEPTH-1:0] scan_idx;
    logic                       done_commit;
    logic                       bypass;
    logic                       head_ready;

    // Pointers beyond FIFO_DEPTH (non-power-of-2 depth) never address a slot.
    assign rp_ok   = 32'(fifo_read_pointer_i) < 32'(FIFO_DEPTH);
    assign wp_ok   = 32'(fifo_write_pointer_i) < 32'(FIFO_DEPTH);
    assign rp_safe = rp_ok ? fifo_read_pointer_i : '0;

    assign done_commit = (state == S_WAIT) && perm_done_i && !flush_i;
    assign bypass      = done_commit && rp_ok && (cur == fifo_read_pointer_i);
    assign head_ready  = rp_ok && ready[rp_safe];

    // One-hot of the slot being pushed; a same-cycle push counts as pending so IDLE can react at once.
    always_comb begin
        push_hit = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            push_hit[i] = fifo_push_i && wp_ok && (32'(fifo_write_pointer_i) == 32'(i));
        end
        pend_eff = (pending & ~{FIFO_DEPTH{flush_i}}) | push_hit;
    end

    // Oldest-first pick: first pending slot at or after the read pointer, wrapping.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        scan_idx = rp_safe;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (!sel_vld && pend_eff[scan_idx]) begin
                sel_vld = 1'b1;
                sel_idx = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
    end

    // Head decryption, with the engine result forwarded in its done cycle.
    assign plain_valid_o = (fifo_valid_i && head_ready) || bypass;
    assign plain_rdata_o = cipher_rdata_i ^ (bypass ? perm_keystream_i : ks[rp_safe]);
    assign busy_o        = (state != S_IDLE) || (|pending);

    // Engine handshake sequencer; a flush after grant must drain the in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cur          <= '0;
            perm_req_o   <= 1'b0;
            perm_nonce_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        state        <= S_REQ;
                        cur          <= sel_idx;
                        perm_req_o   <= 1'b1;
                        perm_nonce_o <= push_hit[sel_idx] ? push_addr_i : addr[sel_idx];
                    end
                end
                S_REQ: begin
                    if (perm_gnt_i) begin
                        perm_req_o <= 1'b0;
                        state      <= flush_i ? S_DRAIN : S_WAIT;
                    end else if (flush_i) begin
                        perm_req_o <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (perm_done_i) begin
                        state <= S_IDLE;
                    end else if (flush_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (perm_done_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Slot bookkeeping: flush, then result commit, then pop, then push (the push wins its slot).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            ready   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr[i] <= '0;
                ks[i]   <= '0;
            end
        end else begin
            if (flush_i) begin
                pending <= '0;
                ready   <= '0;
            end
            if (done_commit) begin
                pending[cur] <= 1'b0;
                ready[cur]   <= 1'b1;
                ks[cur]      <= perm_keystream_i;
            end
            if (fifo_pop_i && rp_ok) begin
                ready[rp_safe] <= 1'b0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (push_hit[i]) begin
                    pending[i] <= 1'b1;
                    ready[i]   <= 1'b0;
                    addr[i]    <= push_addr_i;
                end
            end
        end
    end

    // Sticky flag: the IF stage consumed a slot whose keystream was not available.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            protocol_err_o <= 1'b0;
        end else if (fifo_pop_i && !head_ready && !bypass) begin
            protocol_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_ascon_ks_scheduler.sv
module tb_cv32e40p_ascon_ks_scheduler;

    logic        clk;
    logic        rst_n;
    logic        fifo_push_i;
    logic [0:0]  fifo_write_pointer_i;
    logic [31:0] push_addr_i;
    logic        fifo_pop_i;
    logic [0:0]  fifo_read_pointer_i;
    logic        fifo_valid_i;
    logic        flush_i;
    logic [31:0] cipher_rdata_i;
    logic [31:0] plain_rdata_o;
    logic        plain_valid_o;
    logic        perm_req_o;
    logic [31:0] perm_nonce_o;
    logic        perm_gnt_i;
    logic        perm_done_i;
    logic [31:0] perm_keystream_i;
    logic        busy_o;
    logic        protocol_err_o;

    int checks = 0;
    int errs   = 0;

    cv32e40p_ascon_ks_scheduler #(.FIFO_DEPTH(2), .FIFO_ADDR_DEPTH(1)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .fifo_push_i          (fifo_push_i),
        .fifo_write_pointer_i (fifo_write_pointer_i),
        .push_addr_i          (push_addr_i),
        .fifo_pop_i           (fifo_pop_i),
        .fifo_read_pointer_i  (fifo_read_pointer_i),
        .fifo_valid_i         (fifo_valid_i),
        .flush_i              (flush_i),
        .cipher_rdata_i       (cipher_rdata_i),
        .plain_rdata_o        (plain_rdata_o),
        .plain_valid_o        (plain_valid_o),
        .perm_req_o           (perm_req_o),
        .perm_nonce_o         (perm_nonce_o),
        .perm_gnt_i           (perm_gnt_i),
        .perm_done_i          (perm_done_i),
        .perm_keystream_i     (perm_keystream_i),
        .busy_o               (busy_o),
        .protocol_err_o       (protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fifo_push_i = 0; fifo_write_pointer_i = 0; push_addr_i = 0;
        fifo_pop_i = 0; fifo_read_pointer_i = 0; fifo_valid_i = 1;
        flush_i = 0; cipher_rdata_i = 0; perm_gnt_i = 0; perm_done_i = 0;
        perm_keystream_i = 0;
        repeat (2) nxt();
        rst_n = 1'b1;
        #1;
        checks++; if (perm_req_o !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", perm_req_o); end
        checks++; if (perm_nonce_o !== 32'h0) begin errs++; $display("FAIL rst_nonce got %h want 0", perm_nonce_o); end
        checks++; if (plain_valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", plain_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy_o); end
        checks++; if (protocol_err_o !== 1'b0) begin errs++; $display("FAIL rst_err got %b want 0", protocol_err_o); end
        fifo_valid_i = 0;
    endtask

    task automatic test_single();
        nxt();
        fifo_push_i = 1; fifo_write_pointer_i = 0; push_addr_i = 32'h0000_0080;
        fifo_valid_i = 1; fifo_read_pointer_i = 0; cipher_rdata_i = 32'h1234_5678;
        #1;
        checks++; if (perm_req_o !== 1'b0) begin errs++; $display("FAIL single_req_early got %b want 0", perm_req_o); end
        nxt();
        fifo_push_i = 0; perm_gnt_i = 1;
        #1;
        checks++; if (perm_req_o !== 1'b1) begin errs++; $display("FAIL single_req got %b want 1", perm_req_o); end
        checks++; if (perm_nonce_o !== 32'h80) begin errs++; $display("FAIL single_nonce got %h want 00000080", perm_nonce_o); end
        nxt();
        perm_gnt_i = 0;
        #1;
        checks++; if (perm_req_o !== 1'b0) begin errs++; $display("FAIL single_req_drop got %b want 0", perm_req_o); end
        checks++; if (busy_o !== 1'b1) begin errs++; $display("FAIL single_busy got %b want 1", busy_o); end
        checks++; if (plain_valid_o !== 1'b0) begin errs++; $display("FAIL single_valid_early got %b want 0", plain_valid_o); end
        nxt();
        nxt();
        perm_done_i = 1; perm_keystream_i = 32'hA5A5_A5A5;
        #1;
        checks++; if (plain_valid_o !== 1'b1) begin errs++; $display("FAIL single_bypass_valid got %b want 1", plain_valid_o); end
        checks++; if (plain_rdata_o !== 32'hB791_F3DD) begin errs++; $display("FAIL single_bypass_data got %h want b791f3dd", plain_rdata_o); end
        nxt();
        perm_done_i = 0; perm_keystream_i = 32'hDEAD_BEEF; fifo_pop_i = 1;
        #1;
        checks++; if (plain_valid_o !== 1'b1) begin errs++; $display("FAIL single_held_valid got %b want 1", plain_valid_o); end
        checks++; if (plain_rdata_o !== 32'hB791_F3DD) begin errs++; $display("FAIL single_held_data got %h want b791f3dd", plain_rdata_o); end
        nxt();
        fifo_pop_i = 0;
        #1;
        checks++; if (plain_valid_o !== 1'b0) begin errs++; $display("FAIL single_popped_valid got %b want 0", plain_valid_o); end
        checks++; if (protocol_err_o !== 1'b0) begin errs++; $display("FAIL single_err got %b want 0", protocol_err_o); end
        checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL single_idle_busy got %b want 0", busy_o); end
        fifo_valid_i = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] k0, k1, c;
        k0 = $urandom; k1 = $urandom; c = $urandom;
        nxt();
        fifo_push_i = 1; fifo_write_pointer_i = 0; push_addr_i = 32'h100; fifo_read_pointer_i = 0;
        nxt();
        fifo_write_pointer_i = 1; push_addr_i = 32'h104; perm_gnt_i = 1;
        #1;
        checks++; if (perm_req_o !== 1'b1 || perm_nonce_o !== 32'h100) begin errs++; $display("FAIL b2b_first req=%b nonce=%h want 1/00000100", perm_req_o, perm_nonce_o); end
        nxt();
        fifo_push_i = 0; perm_gnt_i = 0;
        nxt();
        perm_done_i = 1; perm_keystream_i = k0;
        nxt();
        perm_done_i = 0;
        #1;
        checks++; if (perm_req_o !== 1'b0) begin errs++; $display("FAIL b2b_gap req=%b want 0", perm_req_o); end
        nxt();
        perm_gnt_i = 1;
        #1;
        checks++; if (perm_req_o !== 1'b1 || perm_nonce_o !== 32'h104) begin errs++; $display("FAIL b2b_second req=%b nonce=%h want 1/00000104", perm_req_o, perm_nonce_o); end
        nxt();
        perm_gnt_i = 0;
        nxt();
        perm_done_i = 1; perm_keystream_i = k1;
        nxt();
        perm_done_i = 0; fifo_valid_i = 1; fifo_read_pointer_i = 0; cipher_rdata_i = c; fifo_pop_i = 1;
        #1;
        checks++; if (plain_valid_o !== 1'b1 || plain_rdata_o !== (c ^ k0)) begin errs++; $display("FAIL b2b_slot0 valid=%b data=%h want 1/%h", plain_valid_o, plain_rdata_o, c ^ k0); end
        nxt();
        fifo_read_pointer_i = 1;
        #1;
        checks++; if (plain_valid_o !== 1'b1 || plain_rdata_o !== (c ^ k1)) begin errs++; $display("FAIL b2b_slot1 valid=%b data=%h want 1/%h", plain_valid_o, plain_rdata_o, c ^ k1); end
        nxt();
        fifo_pop_i = 0; fifo_valid_i = 0; fifo_read_pointer_i = 0;
        #1;
        checks++; if (busy_o !== 1'b0 || protocol_err_o !== 1'b0) begin errs++; $display("FAIL b2b_end busy=%b err=%b want 0/0", busy_o, protocol_err_o); end
    endtask

    task automatic test_flush_drain();
        logic [31:0] k, c;
        k = $urandom; c = $urandom;
        nxt();
        fifo_push_i = 1; fifo_write_pointer_i = 0; push_addr_i = 32'h200; fifo_read_pointer_i = 0;
        nxt();
        fifo_push_i = 0; perm_gnt_i = 1;
        #1;
        checks++; if (perm_nonce_o !== 32'h200) begin errs++; $display("FAIL flush_nonce0 got %h want 00000200", perm_nonce_o); end
        nxt();
        perm_gnt_i = 0;
        nxt();
        flush_i = 1; fifo_push_i = 1; fifo_write_pointer_i = 0; push_addr_i = 32'h300;
        nxt();
        flush_i = 0; fifo_push_i = 0;
        #1;
        checks++; if (busy_o !== 1'b1 || perm_req_o !== 1'b0) begin errs++; $display("FAIL flush_drain busy=%b req=%b want 1/0", busy_o, perm_req_o); end
        nxt();
        perm_done_i = 1; perm_keystream_i = $urandom; fifo_valid_i = 1;
        #1;
        checks++; if (plain_valid_o !== 1'b0) begin errs++; $display("FAIL flush_no_bypass valid=%b want 0", plain_valid_o); end
        nxt();
        perm_done_i = 0;
        #1;
        checks++; if (plain_valid_o !== 1'b0 || perm_req_o !== 1'b0) begin errs++; $display("FAIL flush_discard valid=%b req=%b want 0/0", plain_valid_o, perm_req_o); end
        nxt();
        perm_gnt_i = 1;
        #1;
        checks++; if (perm_req_o !== 1'b1 || perm_nonce_o !== 32'h300) begin errs++; $display("FAIL flush_next req=%b nonce=%h want 1/00000300", perm_req_o, perm_nonce_o); end
        nxt();
        perm_gnt_i = 0;
        nxt();
        perm_done_i = 1; perm_keystream_i = k; cipher_rdata_i = c; fifo_pop_i = 1;
        #1;
        checks++; if (plain_valid_o !== 1'b1 || plain_rdata_o !== (c ^ k)) begin errs++; $display("FAIL flush_served valid=%b data=%h want 1/%h", plain_valid_o, plain_rdata_o, c ^ k); end
        nxt();
        perm_done_i = 0; fifo_pop_i = 0; fifo_valid_i = 0;
        #1;
        checks++; if (protocol_err_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL flush_end err=%b busy=%b want 0/0", protocol_err_o, busy_o); end
    endtask

    task automatic test_gnt_hold();
        nxt();
        fifo_push_i = 1; fifo_write_pointer_i = 1; push_addr_i = 32'h600;
        for (int k = 1; k <= 5; k++) begin
            nxt();
            fifo_push_i = 0;
            flush_i = (k == 3);
            #1;
            if (k <= 3) begin
                checks++; if (perm_req_o !== 1'b1 || perm_nonce_o !== 32'h600) begin errs++; $display("FAIL hold_c%0d req=%b nonce=%h want 1/00000600", k, perm_req_o, perm_nonce_o); end
            end else begin
                checks++; if (perm_req_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL hold_dropped_c%0d req=%b busy=%b want 0/0", k, perm_req_o, busy_o); end
            end
        end
        flush_i = 0;
    endtask

    task automatic test_protocol_err();
        nxt();
        fifo_valid_i = 1; fifo_read_pointer_i = 0; fifo_pop_i = 1;
        #1;
        checks++; if (protocol_err_o !== 1'b0) begin errs++; $display("FAIL perr_pre got %b want 0", protocol_err_o); end
        nxt();
        fifo_pop_i = 0;
        #1;
        checks++; if (protocol_err_o !== 1'b1) begin errs++; $display("FAIL perr_set got %b want 1", protocol_err_o); end
        repeat (3) nxt();
        checks++; if (protocol_err_o !== 1'b1) begin errs++; $display("FAIL perr_sticky got %b want 1", protocol_err_o); end
        fifo_valid_i = 0;
    endtask

    task automatic test_reset_mid();
        nxt();
        fifo_push_i = 1; fifo_write_pointer_i = 0; push_addr_i = 32'h700; fifo_read_pointer_i = 0;
        nxt();
        fifo_push_i = 0; perm_gnt_i = 1;
        nxt();
        perm_gnt_i = 0; rst_n = 0; cipher_rdata_i = 0; fifo_valid_i = 1;
        nxt();
        rst_n = 1;
        #1;
        checks++; if (perm_req_o !== 1'b0 || perm_nonce_o !== 32'h0) begin errs++; $display("FAIL mrst_req req=%b nonce=%h want 0/0", perm_req_o, perm_nonce_o); end
        checks++; if (plain_valid_o !== 1'b0 || plain_rdata_o !== 32'h0) begin errs++; $display("FAIL mrst_plain valid=%b data=%h want 0/0", plain_valid_o, plain_rdata_o); end
        checks++; if (busy_o !== 1'b0 || protocol_err_o !== 1'b0) begin errs++; $display("FAIL mrst_flags busy=%b err=%b want 0/0", busy_o, protocol_err_o); end
        nxt();
        perm_done_i = 1; perm_keystream_i = $urandom;
        #1;
        checks++; if (plain_valid_o !== 1'b0) begin errs++; $display("FAIL mrst_stray_done valid=%b want 0", plain_valid_o); end
        nxt();
        perm_done_i = 0;
        #1;
        checks++; if (plain_valid_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL mrst_after valid=%b busy=%b want 0/0", plain_valid_o, busy_o); end
        fifo_valid_i = 0;
    endtask

    // Reference model: a slot holds the keystream the engine returned for its address;
    // the request for a pushed address must carry that address; the head decrypts as cipher ^ ks.
    task automatic test_random();
        logic [31:0] model_ks [2];
        logic        model_rdy [2];
        logic [31:0] a, k, c;
        int          slot, gdel, ddel, n, popnow;
        model_rdy[0] = 0; model_rdy[1] = 0;
        model_ks[0] = 0; model_ks[1] = 0;
        for (int it = 0; it < 24; it++) begin
            slot = $urandom_range(0, 1); a = $urandom; k = $urandom; c = $urandom;
            gdel = $urandom_range(0, 3); ddel = $urandom_range(0, 3); popnow = $urandom_range(0, 1);
            nxt();
            fifo_push_i = 1; fifo_write_pointer_i = slot[0]; push_addr_i = a; fifo_valid_i = 0;
            model_rdy[slot] = 0;
            nxt();
            fifo_push_i = 0;
            #1;
            n = 0;
            while (perm_req_o !== 1'b1 && n < 8) begin
                nxt(); #1; n++;
            end
            checks++; if (perm_req_o !== 1'b1 || perm_nonce_o !== a) begin errs++; $display("FAIL rnd%0d_req req=%b nonce=%h want 1/%h", it, perm_req_o, perm_nonce_o, a); end
            for (int d = 0; d < gdel; d++) begin
                nxt(); #1;
                checks++; if (perm_req_o !== 1'b1 || perm_nonce_o !== a) begin errs++; $display("FAIL rnd%0d_stable req=%b nonce=%h want 1/%h", it, perm_req_o, perm_nonce_o, a); end
            end
            perm_gnt_i = 1;
            nxt();
            perm_gnt_i = 0;
            repeat (ddel) nxt();
            perm_done_i = 1; perm_keystream_i = k; cipher_rdata_i = c;
            fifo_read_pointer_i = slot[0]; fifo_valid_i = 1; fifo_pop_i = (popnow == 1);
            model_ks[slot] = k; model_rdy[slot] = (popnow == 0);
            #1;
            checks++; if (plain_valid_o !== 1'b1 || plain_rdata_o !== (c ^ model_ks[slot])) begin errs++; $display("FAIL rnd%0d_bypass valid=%b data=%h want 1/%h", it, plain_valid_o, plain_rdata_o, c ^ model_ks[slot]); end
            nxt();
            perm_done_i = 0; perm_keystream_i = $urandom; c = $urandom; cipher_rdata_i = c;
            fifo_pop_i = model_rdy[slot];
            #1;
            checks++; if (plain_valid_o !== model_rdy[slot] || (model_rdy[slot] && plain_rdata_o !== (c ^ model_ks[slot]))) begin errs++; $display("FAIL rnd%0d_held valid=%b data=%h want %b/%h", it, plain_valid_o, plain_rdata_o, model_rdy[slot], c ^ model_ks[slot]); end
            model_rdy[slot] = 0;
            nxt();
            fifo_pop_i = 0;
            #1;
            checks++; if (plain_valid_o !== 1'b0) begin errs++; $display("FAIL rnd%0d_popped valid=%b want 0", it, plain_valid_o); end
            fifo_valid_i = 0;
        end
        checks++; if (protocol_err_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL rnd_end err=%b busy=%b want 0/0", protocol_err_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush_drain();
        test_gnt_hold();
        test_protocol_err();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule

// File: doc/cv32e40p_ascon_ks_scheduler.md
Name: cv32e40p_ascon_ks_scheduler

Overview:
- Sequences the shared ASCON keystream engine for the encrypted instruction-fetch path.
- Tracks each prefetch FIFO slot as the prefetch buffer pushes and pops it.
- Requests one 32-bit keystream word per pushed fetch address and stores it per slot.
- Delivers plaintext (cipher XOR keystream) for the slot at the FIFO read pointer, with a valid flag the IF stage uses to stall.

Parameters:
FIFO_DEPTH, 2, number of prefetch FIFO slots tracked
FIFO_ADDR_DEPTH, 1, width of FIFO read/write pointers (2**FIFO_ADDR_DEPTH >= FIFO_DEPTH)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
fifo_push_i  in  1  prefetch FIFO write this cycle
fifo_write_pointer_i  in  FIFO_ADDR_DEPTH  slot being written
push_addr_i  in  32  fetch address of the pushed word (keystream nonce)
fifo_pop_i  in  1  prefetch FIFO read this cycle
fifo_read_pointer_i  in  FIFO_ADDR_DEPTH  slot at FIFO head
fifo_valid_i  in  1  FIFO head holds data
flush_i  in  1  branch/pc_set: discard all slots
cipher_rdata_i  in  32  ciphertext at FIFO head
plain_rdata_o  out  32  cipher_rdata_i XOR keystream of the head slot
plain_valid_o  out  1  head slot plaintext usable
perm_req_o  out  1  keystream request to the engine
perm_nonce_o  out  32  address for the request
perm_gnt_i  in  1  engine accepted the request
perm_done_i  in  1  engine result valid (1-cycle pulse)
perm_keystream_i  in  32  keystream word
busy_o  out  1  FSM not IDLE or any slot pending
protocol_err_o  out  1  sticky: pop of a not-ready slot

Behaviour:
- Per-slot state: pending, ready, addr[31:0], ks[31:0]. On reset, all pending/ready = 0; addr and ks = 0.
- FSM states: IDLE, REQ, WAIT, DRAIN. Reset state is IDLE.
- Output reset values: perm_req_o=0, perm_nonce_o=0, plain_valid_o=0, busy_o=0, protocol_err_o=0.
- Push: at the clock edge, the slot at fifo_write_pointer_i gets pending=1, ready=0, addr=push_addr_i.
- Slot selection in IDLE: the first pending slot scanning from fifo_read_pointer_i upward, wrapping modulo FIFO_DEPTH, so the oldest slot is served first. The chosen index is registered as cur.
  - IDLE -> REQ when any slot is pending (registered). A push at cycle t gives perm_req_o=1 at t+1.
- REQ:
  - perm_req_o=1 and perm_nonce_o=addr[cur], both held stable until perm_gnt_i.
  - On gnt, go to WAIT.
  - On flush_i without gnt, go to IDLE and drop the request.
- WAIT:
  - On perm_done_i: ks[cur]=perm_keystream_i, ready[cur]=1, pending[cur]=0, go to IDLE.
  - If flush_i with no done, go to DRAIN.
  - If flush_i and done in the same cycle, discard the result and go to IDLE.
- DRAIN: wait for perm_done_i, discard the result, go to IDLE. The engine cannot be aborted, so no request is issued until the drain finishes.
- Flush: clears all pending and ready bits.
  - A push in the same cycle as a flush wins for its slot (post-branch fetch).
  - busy_o stays 1 while in DRAIN.
- Pop: clears ready[fifo_read_pointer_i] at the edge.
  - Pop while ready=0 and no same-cycle done for that slot sets protocol_err_o. Only reset clears it.
- Combinational outputs:
  - plain_valid_o = fifo_valid_i & ready[rp], with a same-cycle bypass: also 1 when perm_done_i & state==WAIT & cur==rp & !flush_i.
  - plain_rdata_o = cipher_rdata_i ^ (bypass ? perm_keystream_i : ks[rp]).
- Simultaneous events:
  - Pop of slot A with done for slot B: both apply.
  - Push into slot == cur is illegal (the slot has not been popped). It is not checked, and the push overwrites.
- Wrap-around: all pointer arithmetic is modulo FIFO_DEPTH. With non-power-of-2 depth, indices >= FIFO_DEPTH are never selected.
- Reset mid-operation (any state) returns to IDLE with all slots cleared. A later stray perm_done_i in IDLE is ignored.
- Pointers are owned by the prefetch buffer; this block never modifies them.

Test Plan:
- Push addr 0x0000_0080 into slot 0; gnt next cycle; done 3 cycles later with ks 0xA5A5_A5A5; cipher 0x1234_5678 -> plain_rdata_o=0xB791_F3DD, plain_valid_o=1 in the same cycle as done (bypass), and held after.
- Push slot 0 (0x100) and slot 1 (0x104) back-to-back -> requests issued in order 0x100 then 0x104. The second perm_req_o rises 2 cycles after the first done (IDLE, then REQ).
- Flush during WAIT for 0x200, push 0x300 on the flush cycle -> DRAIN. The done for 0x200 is discarded (ready stays 0). The next request nonce is 0x300.
- Hold perm_gnt_i low 5 cycles -> perm_req_o and perm_nonce_o stay stable. Flush at cycle 3 -> perm_req_o=0 next cycle, FSM in IDLE.
- Pop with ready=0, fifo_valid_i=1 -> protocol_err_o=1 and it stays 1. Reset -> 0.
- rst_n low while in WAIT -> next cycle all outputs 0. A done pulse after reset leaves plain_valid_o=0.
